// File: rtl/capture_pkg.sv
// Shared types for the motor probe capture block: FSM states, trigger modes and timestamp width.
package capture_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PRE       = 3'd1,
      ST_WAIT_TRIG = 3'd2,
      ST_POST      = 3'd3,
      ST_DONE      = 3'd4,
      ST_READ      = 3'd5
   } state_e;

   localparam logic [1:0] TRIG_LEVEL  = 2'b00;
   localparam logic [1:0] TRIG_RISE   = 2'b01;
   localparam logic [1:0] TRIG_CHANGE = 2'b10;
   localparam logic [1:0] TRIG_FORCE  = 2'b11;

   localparam int TS_W = 16;

endpackage

// File: rtl/motor_probe_capture_if.sv
// Readout stream of the probe capture buffer: valid/ready handshake with a last-word marker.
interface motor_probe_capture_if #(
   parameter int DW = 9
);
   logic          rd_valid_o;
   logic          rd_ready_i;
   logic [DW-1:0] rd_data_o;
   logic          rd_last_o;

   modport master (output rd_valid_o, output rd_data_o, output rd_last_o, input rd_ready_i);
   modport slave  (input rd_valid_o, input rd_data_o, input rd_last_o, output rd_ready_i);
endinterface

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: one write port, one synchronous read port; contents are never reset.
module capture_ram #(
   parameter  int DEPTH = 256,
   parameter  int DW    = 9,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);
   logic [DW-1:0] mem [DEPTH];

   // rdata_o holds its value while re_i is low; the readout uses it as its prefetch slot.
   always_ff @(posedge clk_i) begin
      if (we_i) mem[waddr_i] <= wdata_i;
      if (re_i) rdata_o <= mem[raddr_i];
   end
endmodule

// File: rtl/motor_probe_capture.sv
// Triggered logic-analyser capture of motor/driver probe lines with pre-trigger history and streamed readout.
// Optional feature: define CAPTURE_TIMESTAMP_EN to store a 16-bit strobe counter above each sample.
module motor_probe_capture
   import capture_pkg::*;
#(
   parameter int CH_W  = 9,
   parameter int DEPTH = 256
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic [CH_W-1:0]          probe_i,
   input  logic                     sample_en_i,
   input  logic                     arm_i,
   input  logic                     abort_i,
   input  logic [1:0]               trig_mode_i,
   input  logic [CH_W-1:0]          trig_mask_i,
   input  logic [CH_W-1:0]          trig_value_i,
   input  logic [$clog2(DEPTH)-1:0] pretrig_i,
   output logic [2:0]               state_o,
   output logic                     done_o,
   motor_probe_capture_if.master    rd
);
   localparam int AW = $clog2(DEPTH);
`ifdef CAPTURE_TIMESTAMP_EN
   localparam int DW = CH_W + TS_W;
   localparam logic [TS_W-1:0] TS_ONE = TS_W'(1);
`else
   localparam int DW = CH_W;
`endif
   localparam logic [AW-1:0] ONE    = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

   state_e          state;
   logic [CH_W-1:0] sync_p0, sync_p1, prev_s;
   logic [1:0]      mode_q;
   logic [CH_W-1:0] mask_q, value_q;
   logic [AW-1:0]   pre_q, wr_ptr, post_left, rd_start, rd_addr;
   logic [AW:0]     rd_issued;
   logic            ram_vld, ram_last;
   logic [DW-1:0]   wr_data, ram_q;
   logic            arm_go, wr_en, match_now, match_prev, trig_hit;
   logic            fire, load, issue;
`ifdef CAPTURE_TIMESTAMP_EN
   logic [TS_W-1:0] ts;
   assign wr_data = {ts, sync_p1};
`else
   assign wr_data = sync_p1;
`endif

   assign state_o    = state;
   assign arm_go     = arm_i & ~abort_i & (state == ST_IDLE);
   assign wr_en      = sample_en_i & (state inside {ST_PRE, ST_WAIT_TRIG, ST_POST});
   assign match_now  = ((sync_p1 ^ value_q) & mask_q) == '0;
   assign match_prev = ((prev_s ^ value_q) & mask_q) == '0;

   always_comb begin
      case (mode_q)
         TRIG_LEVEL:  trig_hit = match_now;
         TRIG_RISE:   trig_hit = match_now & ~match_prev;
         TRIG_CHANGE: trig_hit = |((sync_p1 ^ prev_s) & mask_q);
         default:     trig_hit = 1'b1;
      endcase
   end

   // A new RAM read is issued whenever the prefetched word is absent or moves to the output this cycle.
   assign fire    = rd.rd_valid_o & rd.rd_ready_i;
   assign load    = ram_vld & (~rd.rd_valid_o | rd.rd_ready_i);
   assign issue   = (state inside {ST_DONE, ST_READ}) & ~rd_issued[AW] & (~ram_vld | load);
   assign rd_addr = rd_start + rd_issued[AW-1:0];

   capture_ram #(.DEPTH(DEPTH), .DW(DW)) u_ram (
      .clk_i   (clk_i),
      .we_i    (wr_en),
      .waddr_i (wr_ptr),
      .wdata_i (wr_data),
      .re_i    (issue),
      .raddr_i (rd_addr),
      .rdata_o (ram_q)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state          <= ST_IDLE;
         sync_p0        <= '0;
         sync_p1        <= '0;
         prev_s         <= '0;
         mode_q         <= TRIG_LEVEL;
         mask_q         <= '0;
         value_q        <= '0;
         pre_q          <= '0;
         wr_ptr         <= '0;
         post_left      <= '0;
         rd_start       <= '0;
         rd_issued      <= '0;
         ram_vld        <= 1'b0;
         ram_last       <= 1'b0;
         done_o         <= 1'b0;
         rd.rd_valid_o  <= 1'b0;
         rd.rd_last_o   <= 1'b0;
         rd.rd_data_o   <= '0;
`ifdef CAPTURE_TIMESTAMP_EN
         ts             <= '0;
`endif
      end else begin
         // Synchroniser stage boundary: probe_i -> sync_p0 -> sync_p1.
         sync_p0 <= probe_i;
         sync_p1 <= sync_p0;
         if (sample_en_i) prev_s <= sync_p1;
`ifdef CAPTURE_TIMESTAMP_EN
         if (arm_go) ts <= '0;
         else if (sample_en_i && state != ST_IDLE) ts <= ts + TS_ONE;
`endif
         if (abort_i) begin
            state         <= ST_IDLE;
            done_o        <= 1'b0;
            ram_vld       <= 1'b0;
            rd.rd_valid_o <= 1'b0;
            rd.rd_last_o  <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: if (arm_go) begin
                  mode_q    <= trig_mode_i;
                  mask_q    <= trig_mask_i;
                  value_q   <= trig_value_i;
                  pre_q     <= pretrig_i;
                  wr_ptr    <= '0;
                  rd_issued <= '0;
                  state     <= (pretrig_i == '0) ? ST_WAIT_TRIG : ST_PRE;
               end
               ST_PRE: if (sample_en_i) begin
                  wr_ptr <= wr_ptr + ONE;
                  if (wr_ptr == pre_q - ONE) state <= ST_WAIT_TRIG;
               end
               ST_WAIT_TRIG: if (sample_en_i) begin
                  wr_ptr <= wr_ptr + ONE;
                  if (trig_hit) begin
                     rd_start  <= wr_ptr - pre_q;
                     post_left <= ~pre_q;   // DEPTH-1-pretrig in AW bits
                     if (pre_q == '1) begin
                        state  <= ST_DONE;
                        done_o <= 1'b1;
                     end else begin
                        state  <= ST_POST;
                     end
                  end
               end
               ST_POST: if (sample_en_i) begin
                  wr_ptr    <= wr_ptr + ONE;
                  post_left <= post_left - ONE;
                  if (post_left == ONE) begin
                     state  <= ST_DONE;
                     done_o <= 1'b1;
                  end
               end
               ST_DONE: state <= ST_READ;
               ST_READ: if (fire && rd.rd_last_o) begin
                  state  <= ST_IDLE;
                  done_o <= 1'b0;
               end
               default: state <= ST_IDLE;
            endcase

            if (issue) begin
               rd_issued <= rd_issued + CNT_ONE;
               ram_last  <= &rd_issued[AW-1:0];
            end
            if (issue)     ram_vld <= 1'b1;
            else if (load) ram_vld <= 1'b0;

            // Output stage boundary: prefetched RAM word -> rd_data_o.
            if (load) begin
               rd.rd_valid_o <= 1'b1;
               rd.rd_data_o  <= ram_q;
               rd.rd_last_o  <= ram_last;
            end else if (fire) begin
               rd.rd_valid_o <= 1'b0;
               rd.rd_last_o  <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_motor_probe_capture.sv
// Bench for motor_probe_capture (DEPTH=16): table vectors, hand sequences and randomized captures vs a sample-list model.
module tb_motor_probe_capture;
   import capture_pkg::*;

   localparam int CH_W  = 9;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
`ifdef CAPTURE_TIMESTAMP_EN
   localparam int DW = CH_W + 16;
`else
   localparam int DW = CH_W;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [CH_W-1:0] probe = '0;
   logic            sample_en = 1'b0, arm = 1'b0, abort = 1'b0;
   logic [1:0]      trig_mode = 2'b00;
   logic [CH_W-1:0] trig_mask = '0, trig_value = '0;
   logic [AW-1:0]   pretrig = '0;
   logic [2:0]      state_o;
   logic            done_o;

   always #5 clk = ~clk;

   motor_probe_capture_if #(.DW(DW)) rd_if ();

   motor_probe_capture #(.CH_W(CH_W), .DEPTH(DEPTH)) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .probe_i      (probe),
      .sample_en_i  (sample_en),
      .arm_i        (arm),
      .abort_i      (abort),
      .trig_mode_i  (trig_mode),
      .trig_mask_i  (trig_mask),
      .trig_value_i (trig_value),
      .pretrig_i    (pretrig),
      .state_o      (state_o),
      .done_o       (done_o),
      .rd           (rd_if)
   );

   typedef struct {
      logic [1:0]      mode;
      logic [CH_W-1:0] mask;
      logic [CH_W-1:0] value;
      int              pre;
      logic            hi_start;
      int              fall_at;
      int              rise_at;
      int              pat;
      int              exp_trig;
      int              exp_strobes;
   } vec_t;

   vec_t            vecs [8];
   logic [CH_W-1:0] samp [0:127];
   logic [DW-1:0]   got [0:DEPTH-1];
   logic            got_last [0:DEPTH-1];
   int              pass_cnt = 0;
   int              chk_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Present a probe word long enough to clear the synchroniser, then strobe it once.
   task automatic strobe(input logic [CH_W-1:0] p);
      probe = p;
      sample_en = 1'b0;
      repeat (3) tick();
      sample_en = 1'b1;
      tick();
      sample_en = 1'b0;
   endtask

   function automatic logic mt(input logic [CH_W-1:0] s, input logic [CH_W-1:0] mask,
                               input logic [CH_W-1:0] value);
      return ((s ^ value) & mask) == '0;
   endfunction

   // Strobe index (counted from arm) of the qualifying sample, or -1 if none fits in n strobes.
   function automatic int find_trig(input logic [1:0] mode, input logic [CH_W-1:0] mask,
                                    input logic [CH_W-1:0] value, input logic [CH_W-1:0] prev0,
                                    input int pre, input int n);
      for (int k = pre; k + DEPTH - pre <= n; k++) begin
         logic [CH_W-1:0] pv;
         logic hit;
         pv = (k == 0) ? prev0 : samp[k-1];
         case (mode)
            2'b00:   hit = mt(samp[k], mask, value);
            2'b01:   hit = mt(samp[k], mask, value) && !mt(pv, mask, value);
            2'b10:   hit = ((samp[k] ^ pv) & mask) != '0;
            default: hit = (k == pre);
         endcase
         if (hit) return k;
      end
      return -1;
   endfunction

   function automatic logic [DW-1:0] exp_word(input int k);
`ifdef CAPTURE_TIMESTAMP_EN
      logic [15:0] tsv;
      tsv = 16'(k);
      return {tsv, samp[k]};
`else
      return samp[k];
`endif
   endfunction

   task automatic fill_table(input vec_t v);
      for (int k = 0; k < 128; k++) begin
         logic b0;
         b0 = (k < v.fall_at) ? v.hi_start : (k >= v.rise_at);
         samp[k] = {8'(k), b0};
      end
   endtask

   task automatic read_stream(input int pat, output int nwords, output int span, output int stall_err);
      int cyc, first, last;
      logic prev_stall, rdy;
      logic [DW-1:0] prev_data;
      cyc = 0; first = -1; last = -1; prev_stall = 1'b0; prev_data = '0;
      nwords = 0; stall_err = 0;
      while (nwords < DEPTH && cyc < 400) begin
         case (pat)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 2 == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         rd_if.rd_ready_i = rdy;
         if (prev_stall && (!rd_if.rd_valid_o || rd_if.rd_data_o !== prev_data)) stall_err++;
         if (rd_if.rd_valid_o && rdy) begin
            got[nwords] = rd_if.rd_data_o;
            got_last[nwords] = rd_if.rd_last_o;
            if (first < 0) first = cyc;
            last = cyc;
            nwords++;
         end
         prev_stall = rd_if.rd_valid_o && !rdy;
         prev_data = rd_if.rd_data_o;
         tick();
         cyc++;
      end
      rd_if.rd_ready_i = 1'b0;
      span = last - first + 1;
   endtask

   task automatic run_capture(input string name, input logic [1:0] mode, input logic [CH_W-1:0] mask,
                              input logic [CH_W-1:0] value, input logic [CH_W-1:0] prev0,
                              input int pre, input int n, input int pat, input int exp_trig,
                              input int exp_strobes, input bit do_read);
      int t, nstrobe, nwords, span, serr, want;
      t = find_trig(mode, mask, value, prev0, pre, n);
      if (t < 0 && exp_strobes < 0) return;
      want = (exp_strobes >= 0) ? exp_strobes : t + DEPTH - pre;
      strobe(prev0);
      trig_mode = mode; trig_mask = mask; trig_value = value; pretrig = AW'(pre);
      arm = 1'b1;
      tick();
      arm = 1'b0;
      check({name, "/arm_state"}, state_o, (pre == 0) ? ST_WAIT_TRIG : ST_PRE);
      nstrobe = 0;
      while (!done_o && nstrobe < n) begin
         strobe(samp[nstrobe]);
         nstrobe++;
      end
      check({name, "/strobes_to_done"}, nstrobe, want);
      if (!done_o) begin
         abort = 1'b1; tick(); abort = 1'b0;
         return;
      end
      if (!do_read) return;
      read_stream(pat, nwords, span, serr);
      check({name, "/word_count"}, nwords, DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
         check($sformatf("%s/word%0d", name, i), got[i], exp_word(t - pre + i));
         check($sformatf("%s/last%0d", name, i), got_last[i], (i == DEPTH - 1));
      end
      if (exp_trig >= 0) check({name, "/trig_word"}, got[pre][8:1], exp_trig);
      check({name, "/stall_stable"}, serr, 0);
      if (pat == 0) check({name, "/throughput"}, span, DEPTH);
      check({name, "/end_state"}, state_o, ST_IDLE);
      check({name, "/end_done"}, done_o, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]      rmode;
      logic [CH_W-1:0] rmask, rval, rprev;
      int              rpre, rpat;

      vecs[0] = '{2'b00, 9'h001, 9'h001,  4, 1'b0, 0, 10, 0, 10, 22};
      vecs[1] = '{2'b01, 9'h001, 9'h001,  2, 1'b1, 5,  8, 1,  8, 22};
      vecs[2] = '{2'b11, 9'h000, 9'h000,  0, 1'b0, 0,  0, 2,  0, 16};
      vecs[3] = '{2'b10, 9'h001, 9'h000,  3, 1'b0, 0,  7, 2,  7, 20};
      vecs[4] = '{2'b00, 9'h001, 9'h001, 15, 1'b0, 0,  3, 0, 15, 16};
      vecs[5] = '{2'b00, 9'h1FE, 9'h018,  5, 1'b0, 0, 99, 1, 12, 23};
      vecs[6] = '{2'b00, 9'h000, 9'h000,  1, 1'b0, 0,  0, 2,  1, 16};
      vecs[7] = '{2'b01, 9'h001, 9'h001,  0, 1'b0, 0,  0, 0,  0, 16};

      rd_if.rd_ready_i = 1'b0;
      repeat (3) tick();
      check("reset/state", state_o, ST_IDLE);
      check("reset/done", done_o, 1'b0);
      check("reset/valid", rd_if.rd_valid_o, 1'b0);
      check("reset/last", rd_if.rd_last_o, 1'b0);
      check("reset/data", rd_if.rd_data_o, '0);
      rst_n = 1'b1;
      repeat (2) tick();

      for (int i = 0; i < 8; i++) begin
         fill_table(vecs[i]);
         run_capture($sformatf("vec%0d", i), vecs[i].mode, vecs[i].mask, vecs[i].value,
                     {8'h00, vecs[i].hi_start}, vecs[i].pre, 60, vecs[i].pat,
                     vecs[i].exp_trig, vecs[i].exp_strobes, 1'b1);
      end

      // Abort in POST, with stalled strobes and an ignored arm beforehand.
      for (int k = 0; k < 128; k++) samp[k] = {8'(k), k >= 4};
      strobe('0);
      trig_mode = 2'b00; trig_mask = 9'h001; trig_value = 9'h001; pretrig = 4'd2;
      arm = 1'b1; tick(); arm = 1'b0;
      for (int k = 0; k < 5; k++) strobe(samp[k]);
      check("abort/in_post", state_o, ST_POST);
      repeat (20) tick();
      check("abort/no_strobe_hold", state_o, ST_POST);
      arm = 1'b1; tick(); arm = 1'b0;
      check("abort/arm_ignored", state_o, ST_POST);
      abort = 1'b1; tick(); abort = 1'b0;
      check("abort/state", state_o, ST_IDLE);
      check("abort/done", done_o, 1'b0);
      check("abort/valid", rd_if.rd_valid_o, 1'b0);
      arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
      check("abort/overrides_arm", state_o, ST_IDLE);
      fill_table(vecs[0]);
      run_capture("rearm", vecs[0].mode, vecs[0].mask, vecs[0].value, '0, vecs[0].pre, 60,
                  1, vecs[0].exp_trig, vecs[0].exp_strobes, 1'b1);

      // Asynchronous reset while a word is waiting in the readout.
      fill_table(vecs[6]);
      run_capture("rstread", vecs[6].mode, vecs[6].mask, vecs[6].value, '0, vecs[6].pre, 60,
                  0, vecs[6].exp_trig, vecs[6].exp_strobes, 1'b0);
      repeat (4) tick();
      check("rstread/valid_before", rd_if.rd_valid_o, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("rstread/state", state_o, ST_IDLE);
      check("rstread/done", done_o, 1'b0);
      check("rstread/valid", rd_if.rd_valid_o, 1'b0);
      check("rstread/last", rd_if.rd_last_o, 1'b0);
      check("rstread/data", rd_if.rd_data_o, '0);
      tick();
      rst_n = 1'b1;
      tick();

      for (int r = 0; r < 8; r++) begin
         rmode = 2'($urandom_range(0, 3));
         rmask = CH_W'(1 << $urandom_range(0, CH_W - 1)) | CH_W'(($urandom_range(0, 1)) << $urandom_range(0, CH_W - 1));
         rval  = CH_W'($urandom);
         rprev = CH_W'($urandom);
         rpre  = $urandom_range(0, DEPTH - 1);
         rpat  = $urandom_range(0, 2);
         for (int k = 0; k < 128; k++) samp[k] = CH_W'($urandom);
         run_capture($sformatf("rand%0d", r), rmode, rmask, rval, rprev, rpre, 100, rpat,
                     -1, -1, 1'b1);
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule

// File: doc/motor_probe_capture.md
MOTOR_PROBE_CAPTURE -- requirements
Module: motor_probe_capture

Interface
REQ-001 SHALL have parameter CH_W, default 9: probe channel count (motor phase, driver IN/STANBY/VREF, pulse).
REQ-002 SHALL have parameter DEPTH, default 256: sample buffer depth, power of 2, 16..4096; AW = log2(DEPTH).
REQ-003 SHALL have port clk_i  in  1: the single clock.
REQ-004 SHALL have port rst_n_i  in  1: asynchronous, active-low reset.
REQ-005 SHALL have port probe_i  in  CH_W: asynchronous probe inputs.
REQ-006 SHALL have port sample_en_i  in  1: sample strobe; the block samples only in cycles where it is 1.
REQ-007 SHALL have port arm_i  in  1: single-cycle arm request.
REQ-008 SHALL have port abort_i  in  1: single-cycle abort.
REQ-009 SHALL have port trig_mode_i  in  2: trigger mode select.
REQ-010 SHALL have port trig_mask_i  in  CH_W: trigger channel mask.
REQ-011 SHALL have port trig_value_i  in  CH_W: trigger match value.
REQ-012 SHALL have port pretrig_i  in  AW: number of pre-trigger samples.
REQ-013 SHALL have port state_o  out  3: current FSM state.
REQ-014 SHALL have port done_o  out  1: capture complete, buffer readable.
REQ-015 SHALL have ports rd_valid_o out 1, rd_ready_i in 1, rd_data_o out DW, rd_last_o out 1: readout stream; DW = CH_W, or CH_W+16 with the timestamp feature.

Function
REQ-016 SHALL pass probe_i through a 2-flop synchroniser; the sampled word s is the synchroniser output in strobe cycles.
REQ-017 SHALL define match = ((s ^ trig_value_i) & trig_mask_i) == 0.
REQ-018 SHALL qualify the trigger per mode: 00 level (match); 01 rising match (match now, not at the previous strobe); 10 change (any masked bit differs from the previous strobe); 11 force (first strobe in WAIT_TRIG).
REQ-019 SHALL implement states IDLE, PRE, WAIT_TRIG, POST, DONE, READ.
REQ-020 In IDLE, arm_i SHALL latch mode, mask, value and pretrig, clear the write pointer, and enter PRE, or WAIT_TRIG directly when pretrig is 0.
REQ-021 In PRE, each strobe SHALL write s and increment the pointer; after pretrig writes the FSM SHALL enter WAIT_TRIG; triggers in PRE SHALL be ignored.
REQ-022 In WAIT_TRIG, each strobe SHALL write circularly (pointer wraps DEPTH-1 to 0); the qualifying strobe's sample SHALL be written at trig_addr, and the FSM SHALL enter POST.
REQ-023 POST SHALL write DEPTH-1-pretrig further samples, then enter DONE with done_o=1; if that count is 0, the FSM SHALL go directly to DONE.
REQ-024 The read start address SHALL be (trig_addr - pretrig) mod DEPTH, so the trigger sample is word index pretrig of the stream.
REQ-025 In DONE the FSM SHALL enter READ and stream exactly DEPTH words in order under valid/ready.
REQ-026 The readout SHALL keep rd_data_o stable and rd_valid_o high while rd_ready_i is 0.
REQ-027 The readout SHALL assert rd_last_o with the final word.
REQ-028 The readout SHALL use a prefetch register to hide the 1-cycle RAM read latency, giving full throughput when rd_ready_i stays high.
REQ-029 After the last word is accepted, the FSM SHALL return to IDLE and clear done_o.
REQ-030 arm_i outside IDLE SHALL be ignored.
REQ-031 abort_i SHALL return the FSM to IDLE from any state on the next edge, deassert rd_valid_o and done_o, and override a simultaneous arm_i.
REQ-032 No state SHALL advance capture in cycles with sample_en_i=0; readout does not depend on sample_en_i.

Reset
REQ-033 rst_n_i low SHALL asynchronously force the FSM to IDLE.
REQ-034 rst_n_i low SHALL force done_o, rd_valid_o, rd_last_o and rd_data_o to 0.
REQ-035 rst_n_i low SHALL clear the pointers, synchroniser, previous-sample register and timestamp.
REQ-036 RAM contents SHALL NOT be reset.

Configuration
REQ-037 With CAPTURE_TIMESTAMP_EN defined, a 16-bit counter SHALL increment on every strobe while not in IDLE, wrap 0xFFFF to 0, clear on arm, and be stored as rd_data_o[CH_W+15:CH_W].
REQ-038 Without CAPTURE_TIMESTAMP_EN, DW SHALL equal CH_W and no counter SHALL exist.

Structure
REQ-039 Package capture_pkg SHALL hold the state enum, the trig-mode encodings and TS_W=16.
REQ-040 Sub-module capture_ram SHALL be a simple dual-port RAM, DEPTH x DW, with synchronous read and one write port and one read port.

Verification
REQ-041 Test: DEPTH=16, pretrig=4, mode 00, mask=0x001, value=0x001, probe bit0 rises at strobe 10 -> 16 words, word 4 is the first with bit0=1, rd_last_o on word 15.
REQ-042 Test: mode 01 with bit0 held at 1 before arm -> no trigger until bit0 falls and rises again.
REQ-043 Test: mode 11, pretrig=0 -> trigger on the first strobe; DONE after 15 further strobes.
REQ-044 Test: rd_ready_i toggling 1/0 during readout -> no lost or duplicated words; data stable while stalled.
REQ-045 Test: abort_i in POST -> IDLE next cycle, done_o=0; re-arm -> a correct new capture.
REQ-046 Test: rst_n_i pulsed low mid-READ -> outputs 0 immediately, asynchronously; state_o=IDLE.
